// File: rtl/st7735_stream.sv
// st7735_stream: LCD hardware-reset sequencer plus a FIFO-fed mode-0 SPI streamer for ST7735 panels.
// Define ST7735_DELAY_TOKEN_EN to treat wide command words as microsecond delay tokens.
//
// state    | meaning
// RST_LOW  | LCD RESET driven low for T cycles
// RST_WAIT | RESET released, wait T cycles before accepting words
// IDLE     | waiting for a word in the FIFO
// LOAD     | CS asserted, DC and first bit presented
// SHIFT    | clocking bits out, CLK_DIV cycles per LCD_CLK half-period
// GAP      | CS deasserted for CLK_DIV cycles after a burst
// DELAY    | CS high while a delay token counts down (token build only)
module st7735_stream #(
  parameter int CLK_FREQ_MHZ = 12,
  parameter int DELAY_US     = 120,
  parameter int CLK_DIV      = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        SYSTEM_CLK,
  input  logic        SYSTEM_RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  input  logic        IN_DC,
  input  logic        IN_WIDE,
  output logic        BUSY,
  output logic        CS,
  output logic        MOSI,
  output logic        DC,
  output logic        LCD_CLK,
  output logic        RESET
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [31:0]   T_LAST   = 32'(CLK_FREQ_MHZ * DELAY_US - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, LOAD, SHIFT, GAP, DELAY} state_t;

  state_t        state, state_nxt;
  logic [31:0]   timer;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt, bit_last;
  logic          sclk, dc_q, wide_q;
  logic [15:0]   sr;

  // FIFO entry layout: {wide, dc, data}
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [17:0]   head;
  logic          push, pop, fifo_empty, fifo_full, last_edge, head_token;
  logic [31:0]   delay_last;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign push       = IN_VALID && IN_READY;
  assign bit_last   = wide_q ? 4'd15 : 4'd7;
  assign last_edge  = (state == SHIFT) && (div_cnt == '0) && sclk && (bit_cnt == bit_last);

`ifdef ST7735_DELAY_TOKEN_EN
  logic [31:0] delay_cycles;
  assign head_token   = head[17] & ~head[16];
  assign delay_cycles = 32'(head[15:0]) * 32'(CLK_FREQ_MHZ);
  // a zero-length token still spends one cycle in DELAY
  assign delay_last   = (delay_cycles == '0) ? '0 : delay_cycles - 32'd1;
`else
  assign head_token = 1'b0;
  assign delay_last = T_LAST;
`endif

  assign LCD_CLK = sclk;
  assign MOSI    = sr[15];
  assign DC      = dc_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    CS        = 1'b1;
    RESET     = 1'b1;
    IN_READY  = !fifo_full;
    BUSY      = !fifo_empty;
    case (state)
      RST_LOW: begin
        RESET    = 1'b0;
        IN_READY = 1'b0;
        BUSY     = 1'b1;
        if (timer == '0) state_nxt = RST_WAIT;
      end
      RST_WAIT: begin
        IN_READY = 1'b0;
        BUSY     = 1'b1;
        if (timer == '0) state_nxt = IDLE;
      end
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_token ? DELAY : LOAD;
        end
      end
      LOAD: begin
        CS        = 1'b0;
        BUSY      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        CS   = 1'b0;
        BUSY = 1'b1;
        if (last_edge) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = head_token ? DELAY : LOAD;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (div_cnt == '0) state_nxt = IDLE;
      end
      DELAY: begin
        BUSY = 1'b1;
        if (timer == '0) state_nxt = IDLE;
      end
      default: state_nxt = RST_LOW;
    endcase
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (push) mem[wr_ptr] <= {IN_WIDE, IN_DC, IN_DATA};
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (!SYSTEM_RST_N) begin
      state   <= RST_LOW;
      timer   <= T_LAST;
      div_cnt <= DIV_LAST;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sr      <= '0;
      dc_q    <= 1'b0;
      wide_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        RST_LOW, RST_WAIT, DELAY: timer <= (timer == '0) ? T_LAST : timer - 32'd1;
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            div_cnt <= DIV_LAST;
            sclk    <= ~sclk;
            // MOSI advances only on the falling edge, and never past the last bit
            if (sclk && (bit_cnt != bit_last)) begin
              sr      <= {sr[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        GAP: div_cnt <= (div_cnt == '0) ? DIV_LAST : div_cnt - DW'(1);
        default: ;
      endcase
      if (pop) begin
        div_cnt <= DIV_LAST;
        bit_cnt <= '0;
        if (head_token) begin
          timer <= delay_last;
        end else begin
          sr     <= head[17] ? head[15:0] : {head[7:0], 8'h00};
          dc_q   <= head[16];
          wide_q <= head[17];
        end
      end
    end
  end
endmodule

// File: tb/tb_st7735_stream.sv
// Bench for st7735_stream: directed and random words, with the observed SPI bit stream
// compared against the bit sequence expected from the accepted words.
module tb_st7735_stream;
  localparam int CLK_FREQ_MHZ = 12;
  localparam int DELAY_US     = 2;
  localparam int CLK_DIV      = 2;
  localparam int FIFO_DEPTH   = 8;
  localparam int T            = CLK_FREQ_MHZ * DELAY_US;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_dc = 1'b0;
  logic        in_wide = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, busy, cs, mosi, dc, lcd_clk, reset_pin;

  always #5 clk = ~clk;

  st7735_stream #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
    .DELAY_US    (DELAY_US),
    .CLK_DIV     (CLK_DIV),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .SYSTEM_CLK  (clk),
    .SYSTEM_RST_N(rst_n),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_DATA     (in_data),
    .IN_DC       (in_dc),
    .IN_WIDE     (in_wide),
    .BUSY        (busy),
    .CS          (cs),
    .MOSI        (mosi),
    .DC          (dc),
    .LCD_CLK     (lcd_clk),
    .RESET       (reset_pin)
  );

  int checks = 0;
  int failures = 0;
  logic [1:0]  bits_q[$];  // {dc, mosi} captured at each LCD_CLK rise
  logic [17:0] exp_q[$];   // accepted SPI words {wide, dc, data}
  int   bad_hi = 0, bad_mosi = 0, bad_cs = 0, hi_len = 0;
  logic prev_clk = 1'b0, prev_mosi = 1'b0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_token(input logic wide, input logic dcb);
`ifdef ST7735_DELAY_TOKEN_EN
    return wide && !dcb;
`else
    return 1'b0;
`endif
  endfunction

  // expected stream: each word MSB first, 16 or 8 bits, DC held for the word
  function automatic int stream_errors();
    int pos, errs, n;
    pos = 0;
    errs = 0;
    foreach (exp_q[w]) begin
      n = exp_q[w][17] ? 16 : 8;
      for (int b = n - 1; b >= 0; b--) begin
        if (pos >= bits_q.size() || bits_q[pos] !== {exp_q[w][16], exp_q[w][b]}) errs++;
        pos++;
      end
    end
    if (bits_q.size() > pos) errs += bits_q.size() - pos;
    return errs;
  endfunction

  function automatic int expected_bits();
    int total;
    total = 0;
    foreach (exp_q[w]) total += exp_q[w][17] ? 16 : 8;
    return total;
  endfunction

  always @(negedge clk) begin
    if (lcd_clk === 1'b1) begin
      if (prev_clk !== 1'b1) begin
        bits_q.push_back({dc, mosi});
        if (cs !== 1'b0) bad_cs++;
        hi_len = 1;
      end else begin
        hi_len++;
        if (mosi !== prev_mosi) bad_mosi++;
      end
    end else if (prev_clk === 1'b1 && hi_len != CLK_DIV) begin
      bad_hi++;
    end
    prev_clk  = lcd_clk;
    prev_mosi = mosi;
  end

  task automatic push_word(input logic wide, input logic dcb, input logic [15:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_wide  = wide;
    in_dc    = dcb;
    in_data  = d;
    while (in_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkn("push_accepted", int'(guard < 2000), 1);
    if (!is_token(wide, dcb)) exp_q.push_back({wide, dcb, d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_cs_low(input string tag);
    int guard;
    guard = 0;
    while (cs !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkn(tag, int'(guard < 2000), 1);
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkn(tag, int'(guard < 5000), 1);
    repeat (CLK_DIV + 3) @(negedge clk);
  endtask

  // expects rst_n low with at least one reset edge already seen
  task automatic run_reset_seq(input string tag);
    int n_low, n_wait, bad;
    check1({tag, "_rst_cs"}, cs, 1'b1);
    check1({tag, "_rst_sclk"}, lcd_clk, 1'b0);
    check1({tag, "_rst_mosi"}, mosi, 1'b0);
    check1({tag, "_rst_dc"}, dc, 1'b0);
    check1({tag, "_rst_reset"}, reset_pin, 1'b0);
    check1({tag, "_rst_ready"}, in_ready, 1'b0);
    check1({tag, "_rst_busy"}, busy, 1'b1);
    rst_n = 1'b1;
    n_low = 0;
    bad = 0;
    while (reset_pin === 1'b0 && n_low < 1000) begin
      if (cs !== 1'b1 || lcd_clk !== 1'b0 || busy !== 1'b1) bad++;
      n_low++;
      @(negedge clk);
    end
    checkn({tag, "_reset_low_cycles"}, n_low, T);
    n_wait = 0;
    while (in_ready !== 1'b1 && n_wait < 1000) begin
      if (reset_pin !== 1'b1 || cs !== 1'b1 || lcd_clk !== 1'b0) bad++;
      n_wait++;
      @(negedge clk);
    end
    checkn({tag, "_reset_wait_cycles"}, n_wait, T);
    checkn({tag, "_reset_pins_steady"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, gap, busy_low, idx, first_stall, guard;
    logic [17:0] words [12];

    // reset sequence
    repeat (3) @(negedge clk);
    run_reset_seq("boot");
    check1("idle_busy", busy, 1'b0);
    check1("idle_cs", cs, 1'b1);

    // single 8-bit command
    bits_q.delete();
    exp_q.delete();
    push_word(1'b0, 1'b0, 16'h0011);
    n = 1;
    while (cs !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkn("cmd_latency", n, 2);
    check1("cmd_load_dc", dc, 1'b0);
    check1("cmd_load_mosi", mosi, 1'b0);
    len = 0;
    while (cs === 1'b0 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    checkn("cmd_cs_low_cycles", len, 1 + 2 * 8 * CLK_DIV);
    wait_idle("cmd_idle");
    checkn("cmd_bit_count", bits_q.size(), 8);
    checkn("cmd_stream", stream_errors(), 0);

    // wide pixel then 8-bit data, back to back
    bits_q.delete();
    exp_q.delete();
    push_word(1'b1, 1'b1, 16'hF800);
    push_word(1'b0, 1'b1, 16'h00A5);
    wait_cs_low("burst_start");
    len = 0;
    while (cs === 1'b0 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    checkn("burst_cs_low_cycles", len, (1 + 2 * 16 * CLK_DIV) + (1 + 2 * 8 * CLK_DIV));
    wait_idle("burst_idle");
    checkn("burst_bit_count", bits_q.size(), 24);
    checkn("burst_stream", stream_errors(), 0);

    // flow control: 12 random words with IN_VALID held high
    bits_q.delete();
    exp_q.delete();
    foreach (words[i]) begin
      words[i] = 18'($urandom);
      if (is_token(words[i][17], words[i][16])) words[i][16] = 1'b1;
    end
    idx = 0;
    first_stall = -1;
    guard = 0;
    while (idx < 12 && guard < 5000) begin
      in_valid = 1'b1;
      {in_wide, in_dc, in_data} = words[idx];
      if (in_ready === 1'b1) begin
        exp_q.push_back(words[idx]);
        idx++;
      end else if (first_stall < 0) begin
        first_stall = idx;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    checkn("flow_all_accepted", idx, 12);
    // the first word leaves the FIFO one cycle after it lands, so one extra word fits
    checkn("flow_first_stall", first_stall, FIFO_DEPTH + 1);
    wait_idle("flow_idle");
    checkn("flow_bit_count", bits_q.size(), expected_bits());
    checkn("flow_stream", stream_errors(), 0);

`ifdef ST7735_DELAY_TOKEN_EN
    // delay token between two commands
    bits_q.delete();
    exp_q.delete();
    push_word(1'b0, 1'b0, 16'h0011);
    push_word(1'b1, 1'b0, 16'd5);
    push_word(1'b0, 1'b0, 16'h0029);
    wait_cs_low("token_start");
    len = 0;
    while (cs === 1'b0 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    checkn("token_first_cs_low", len, 1 + 2 * 8 * CLK_DIV);
    gap = 0;
    busy_low = 0;
    while (cs === 1'b1 && gap < 1000) begin
      if (busy !== 1'b1) busy_low++;
      gap++;
      @(negedge clk);
    end
    checkn("token_gap_at_least_5us", int'(gap >= 5 * CLK_FREQ_MHZ), 1);
    checkn("token_busy_low_cycles", busy_low, 0);
    wait_idle("token_idle");
    checkn("token_bit_count", bits_q.size(), 16);
    checkn("token_stream", stream_errors(), 0);
`endif

    checkn("sclk_high_width_errors", bad_hi, 0);
    checkn("mosi_change_while_high", bad_mosi, 0);
    checkn("sclk_rise_with_cs_high", bad_cs, 0);

    // reset during bit 3 with more words still queued
    bits_q.delete();
    exp_q.delete();
    push_word(1'b0, 1'b1, 16'h00FF);
    push_word(1'b1, 1'b1, 16'hABCD);
    push_word(1'b0, 1'b1, 16'h0055);
    guard = 0;
    while (bits_q.size() < 3 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkn("abort_reached_bit3", int'(guard < 500), 1);
    rst_n = 1'b0;
    @(negedge clk);
    bits_q.delete();
    run_reset_seq("abort");
    repeat (40) @(negedge clk);
    checkn("abort_fifo_flushed_bits", bits_q.size(), 0);
    check1("abort_idle_busy", busy, 1'b0);
    check1("abort_idle_cs", cs, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
